ball_field: RTL and testbench

BALL_FIELD -- requirements
Module: ball_field

---
 rtl/ball_field.sv | 159 +++++++++++++++
 tb/tb_ball_field.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_field.sv
// Bouncing-ball sprite field: one ball position update per cycle after each frame
// start, and a registered per-pixel hit test against the stored ball positions.
module ball_field #(
  parameter int N_BALLS      = 8,
  parameter int X_RES        = 640,
  parameter int Y_RES        = 480,
  parameter int BALL_SIZE    = 16,
  parameter int START_STEP_X = 40,
  parameter int START_STEP_Y = 24,
  parameter int CNT_W        = 11,
  localparam int IDX_W       = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
  input  logic             pclk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] i_hcnt,
  input  logic [CNT_W-1:0] i_vcnt,
  input  logic             i_frame_start,
  input  logic             i_enable,
  input  logic [1:0]       i_speed,
  output logic             o_draw,
  output logic [IDX_W-1:0] o_index,
  output logic             o_busy,
  output logic [15:0]      o_bounce_cnt
);

  localparam int X_SPAN = X_RES - BALL_SIZE;
  localparam int Y_SPAN = Y_RES - BALL_SIZE;
  localparam logic [CNT_W-1:0] LIM_X = CNT_W'(X_SPAN);
  localparam logic [CNT_W-1:0] LIM_Y = CNT_W'(Y_SPAN);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       speed_q, speed_d;
  logic [CNT_W-1:0] pos_x_q [N_BALLS];
  logic [CNT_W-1:0] pos_x_d [N_BALLS];
  logic [CNT_W-1:0] pos_y_q [N_BALLS];
  logic [CNT_W-1:0] pos_y_d [N_BALLS];
  logic [N_BALLS-1:0] neg_x_q, neg_x_d, neg_y_q, neg_y_d;
  logic [15:0]      bounce_q, bounce_d;
  logic             draw_q, draw_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [CNT_W-1:0] step_x, step_y;
  logic [CNT_W:0]   mv_x, mv_y;

  function automatic logic [CNT_W-1:0] start_pos(input int i, input int step, input int span);
    return CNT_W'((i * step) % span);
  endfunction

  // Returns {flip, new_pos}; the sum is one bit wider so it can never wrap.
  function automatic logic [CNT_W:0] axis_move(input logic [CNT_W-1:0] pos,
                                               input logic             neg,
                                               input logic [CNT_W-1:0] step,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (!neg) begin
      if (sum >= {1'b0, lim}) return {1'b1, lim};
      return {1'b0, sum[CNT_W-1:0]};
    end
    if (pos <= step) return {1'b1, {CNT_W{1'b0}}};
    return {1'b0, pos - step};
  endfunction

  function automatic logic [15:0] bounce_sat(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic inside_ball(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] p);
    return ({1'b0, c} >= {1'b0, p}) &&
           ({1'b0, c} < ({1'b0, p} + (CNT_W+1)'(BALL_SIZE)));
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    speed_d  = speed_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    neg_x_d  = neg_x_q;
    neg_y_d  = neg_y_q;
    bounce_d = bounce_q;
    step_x   = '0;
    step_y   = '0;
    mv_x     = '0;
    mv_y     = '0;
    case (state_q)
      IDLE: begin
        if (i_frame_start && i_enable) begin
          state_d = UPDATE;
          idx_d   = '0;
          speed_d = i_speed;
        end
      end
      UPDATE: begin
        step_x = CNT_W'(1 + int'(idx_q) % 4) << speed_q;
        step_y = CNT_W'(1 + (int'(idx_q) + 1) % 4) << speed_q;
        mv_x   = axis_move(pos_x_q[idx_q], neg_x_q[idx_q], step_x, LIM_X);
        mv_y   = axis_move(pos_y_q[idx_q], neg_y_q[idx_q], step_y, LIM_Y);
        pos_x_d[idx_q] = mv_x[CNT_W-1:0];
        pos_y_d[idx_q] = mv_y[CNT_W-1:0];
        neg_x_d[idx_q] = neg_x_q[idx_q] ^ mv_x[CNT_W];
        neg_y_d[idx_q] = neg_y_q[idx_q] ^ mv_y[CNT_W];
        bounce_d = bounce_sat(bounce_q, {1'b0, mv_x[CNT_W]} + {1'b0, mv_y[CNT_W]});
        if (idx_q == IDX_W'(N_BALLS - 1)) state_d = IDLE;
        else                              idx_d   = idx_q + 1'b1;
      end
    endcase
  end

  // Descending scan so the lowest-index hit is the one that sticks.
  always_comb begin
    draw_d  = 1'b0;
    index_d = '0;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (inside_ball(i_hcnt, pos_x_q[i]) && inside_ball(i_vcnt, pos_y_q[i])) begin
        draw_d  = 1'b1;
        index_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      speed_q  <= '0;
      neg_x_q  <= '0;
      neg_y_q  <= '0;
      bounce_q <= '0;
      draw_q   <= 1'b0;
      index_q  <= '0;
      for (int i = 0; i < N_BALLS; i++) begin
        pos_x_q[i] <= start_pos(i, START_STEP_X, X_SPAN);
        pos_y_q[i] <= start_pos(i, START_STEP_Y, Y_SPAN);
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      speed_q  <= speed_d;
      neg_x_q  <= neg_x_d;
      neg_y_q  <= neg_y_d;
      bounce_q <= bounce_d;
      draw_q   <= draw_d;
      index_q  <= index_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
    end
  end

  assign o_draw       = draw_q;
  assign o_index      = index_q;
  assign o_busy       = (state_q == UPDATE);
  assign o_bounce_cnt = bounce_q;

endmodule

// File: tb/tb_ball_field.sv
// Directed bench for ball_field: three instances (tiny 1-ball field, 2 stacked
// balls, default 8-ball field) share clock, reset and inputs.
module tb_ball_field;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] hcnt = '0, vcnt = '0;
  logic        fs = 1'b0, en = 1'b1;
  logic [1:0]  spd = 2'd0;

  logic        s_draw, s_busy, z_draw, z_busy, d_draw, d_busy;
  logic [0:0]  s_index, z_index;
  logic [2:0]  d_index;
  logic [15:0] s_bounce, z_bounce, d_bounce;

  int n_vec = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  ball_field #(.N_BALLS(1), .X_RES(64), .Y_RES(48), .BALL_SIZE(8)) u_small (
    .pclk(pclk), .reset_n(reset_n), .i_hcnt(hcnt), .i_vcnt(vcnt),
    .i_frame_start(fs), .i_enable(en), .i_speed(spd),
    .o_draw(s_draw), .o_index(s_index), .o_busy(s_busy), .o_bounce_cnt(s_bounce));

  ball_field #(.N_BALLS(2), .START_STEP_X(0), .START_STEP_Y(0)) u_zero (
    .pclk(pclk), .reset_n(reset_n), .i_hcnt(hcnt), .i_vcnt(vcnt),
    .i_frame_start(fs), .i_enable(en), .i_speed(spd),
    .o_draw(z_draw), .o_index(z_index), .o_busy(z_busy), .o_bounce_cnt(z_bounce));

  ball_field u_dflt (
    .pclk(pclk), .reset_n(reset_n), .i_hcnt(hcnt), .i_vcnt(vcnt),
    .i_frame_start(fs), .i_enable(en), .i_speed(spd),
    .o_draw(d_draw), .o_index(d_index), .o_busy(d_busy), .o_bounce_cnt(d_bounce));

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; fs = 1'b0; en = 1'b1; spd = 2'd0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic probe(input int h, input int v);
    hcnt = 11'(h);
    vcnt = 11'(v);
    tick();
  endtask

  task automatic frame();
    fs = 1'b1;
    tick();
    fs = 1'b0;
    repeat (9) tick();
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({s_draw, s_busy, s_bounce, s_index} !== 19'h0) begin
      n_err++; $display("FAIL reset_small: got draw=%b busy=%b bounce=%0d idx=%0d, want all 0", s_draw, s_busy, s_bounce, s_index);
    end
    n_vec++;
    if ({d_draw, d_busy, d_bounce, d_index} !== 21'h0) begin
      n_err++; $display("FAIL reset_dflt: got draw=%b busy=%b bounce=%0d idx=%0d, want all 0", d_draw, d_busy, d_bounce, d_index);
    end
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    n_vec++;
    if (d_busy !== 1'b0 || s_busy !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset: got busy d=%b s=%b, want 0", d_busy, s_busy);
    end
  endtask

  task automatic test_hit_after_reset();
    apply_reset();
    probe(7, 7);
    n_vec++;
    if (s_draw !== 1'b1 || s_index !== 1'b0) begin
      n_err++; $display("FAIL hit_7_7: got draw=%b idx=%0d, want 1/0", s_draw, s_index);
    end
    hcnt = 11'd8;
    #1;
    n_vec++;
    if (s_draw !== 1'b1) begin
      n_err++; $display("FAIL latency_hold: got draw=%b before edge, want 1", s_draw);
    end
    tick();
    n_vec++;
    if (s_draw !== 1'b0) begin
      n_err++; $display("FAIL miss_8_7: got draw=%b, want 0", s_draw);
    end
    probe(7, 8);
    n_vec++;
    if (s_draw !== 1'b0 || s_index !== 1'b0) begin
      n_err++; $display("FAIL miss_7_8: got draw=%b idx=%0d, want 0/0", s_draw, s_index);
    end
  endtask

  task automatic test_overlap();
    apply_reset();
    probe(3, 3);
    n_vec++;
    if (z_draw !== 1'b1 || z_index !== 1'b0) begin
      n_err++; $display("FAIL overlap_low_idx: got draw=%b idx=%0d, want 1/0", z_draw, z_index);
    end
    probe(45, 30);
    n_vec++;
    if (d_draw !== 1'b1 || d_index !== 3'd1) begin
      n_err++; $display("FAIL dflt_ball1: got draw=%b idx=%0d, want 1/1", d_draw, d_index);
    end
  endtask

  task automatic test_single_frame();
    apply_reset();
    fs = 1'b1;
    tick();
    fs = 1'b0;
    n_vec++;
    if (s_busy !== 1'b1) begin
      n_err++; $display("FAIL busy_on: got %b, want 1", s_busy);
    end
    tick();
    n_vec++;
    if (s_busy !== 1'b0) begin
      n_err++; $display("FAIL busy_one_cycle: got %b, want 0", s_busy);
    end
    repeat (8) tick();
    probe(1, 2);
    n_vec++;
    if (s_draw !== 1'b1) begin
      n_err++; $display("FAIL pos_1_2: got draw=%b, want 1", s_draw);
    end
    probe(0, 2);
    n_vec++;
    if (s_draw !== 1'b0) begin
      n_err++; $display("FAIL pos_x_edge: got draw=%b, want 0", s_draw);
    end
    probe(1, 1);
    n_vec++;
    if (s_draw !== 1'b0 || s_bounce !== 16'd0) begin
      n_err++; $display("FAIL pos_y_edge: got draw=%b bounce=%0d, want 0/0", s_draw, s_bounce);
    end
  endtask

  task automatic test_bounce();
    frames(19);
    n_vec++;
    if (s_bounce !== 16'd1) begin
      n_err++; $display("FAIL bounce_f20: got %0d, want 1", s_bounce);
    end
    probe(20, 40);
    n_vec++;
    if (s_draw !== 1'b1) begin
      n_err++; $display("FAIL pos_f20: got draw=%b at (20,40), want 1", s_draw);
    end
    probe(20, 39);
    n_vec++;
    if (s_draw !== 1'b0) begin
      n_err++; $display("FAIL pos_f20_above: got draw=%b at (20,39), want 0", s_draw);
    end
    frame();
    probe(21, 38);
    n_vec++;
    if (s_draw !== 1'b1) begin
      n_err++; $display("FAIL y_neg_f21: got draw=%b at (21,38), want 1", s_draw);
    end
    probe(21, 37);
    n_vec++;
    if (s_draw !== 1'b0) begin
      n_err++; $display("FAIL y_neg_f21_above: got draw=%b at (21,37), want 0", s_draw);
    end
    frames(19);
    probe(40, 0);
    n_vec++;
    if (s_draw !== 1'b1 || s_bounce !== 16'd2) begin
      n_err++; $display("FAIL f40: got draw=%b bounce=%0d, want 1/2", s_draw, s_bounce);
    end
    probe(39, 0);
    n_vec++;
    if (s_draw !== 1'b0) begin
      n_err++; $display("FAIL f40_left: got draw=%b at (39,0), want 0", s_draw);
    end
    frames(16);
    probe(56, 32);
    n_vec++;
    if (s_draw !== 1'b1 || s_bounce !== 16'd3) begin
      n_err++; $display("FAIL f56: got draw=%b bounce=%0d, want 1/3", s_draw, s_bounce);
    end
    probe(55, 32);
    n_vec++;
    if (s_draw !== 1'b0) begin
      n_err++; $display("FAIL f56_left: got draw=%b at (55,32), want 0", s_draw);
    end
    frame();
    probe(55, 34);
    n_vec++;
    if (s_draw !== 1'b1) begin
      n_err++; $display("FAIL x_neg_f57: got draw=%b at (55,34), want 1", s_draw);
    end
    probe(54, 34);
    n_vec++;
    if (s_draw !== 1'b0) begin
      n_err++; $display("FAIL x_neg_f57_left: got draw=%b at (54,34), want 0", s_draw);
    end
  endtask

  task automatic test_reset_mid_sweep();
    en = 1'b1; spd = 2'd0;
    fs = 1'b1;
    tick();
    fs = 1'b0;
    tick();
    tick();
    n_vec++;
    if (d_busy !== 1'b1) begin
      n_err++; $display("FAIL sweep_cycle3: got busy=%b, want 1", d_busy);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (d_busy !== 1'b0 || d_draw !== 1'b0 || d_bounce !== 16'd0 || s_bounce !== 16'd0) begin
      n_err++; $display("FAIL async_reset: got busy=%b draw=%b bounce d=%0d s=%0d, want 0", d_busy, d_draw, d_bounce, s_bounce);
    end
    tick();
    reset_n = 1'b1;
    probe(0, 1);
    n_vec++;
    if (d_draw !== 1'b1 || d_index !== 3'd0) begin
      n_err++; $display("FAIL ball0_restart: got draw=%b idx=%0d, want 1/0", d_draw, d_index);
    end
    probe(16, 2);
    n_vec++;
    if (d_draw !== 1'b0) begin
      n_err++; $display("FAIL ball0_not_moved: got draw=%b at (16,2), want 0", d_draw);
    end
    probe(40, 24);
    n_vec++;
    if (d_draw !== 1'b1 || d_index !== 3'd1 || d_busy !== 1'b0) begin
      n_err++; $display("FAIL ball1_restart: got draw=%b idx=%0d busy=%b, want 1/1/0", d_draw, d_index, d_busy);
    end
  endtask

  task automatic test_enable_speed();
    apply_reset();
    en = 1'b0;
    for (int f = 0; f < 10; f++) begin
      fs = 1'b1;
      tick();
      fs = 1'b0;
      n_vec++;
      if (s_busy !== 1'b0 || d_busy !== 1'b0) begin
        n_err++; $display("FAIL disabled_busy f%0d: got s=%b d=%b, want 0", f, s_busy, d_busy);
      end
      repeat (9) tick();
    end
    probe(0, 0);
    n_vec++;
    if (s_draw !== 1'b1) begin
      n_err++; $display("FAIL frozen_origin: got draw=%b, want 1", s_draw);
    end
    probe(8, 2);
    n_vec++;
    if (s_draw !== 1'b0) begin
      n_err++; $display("FAIL frozen_not_moved: got draw=%b at (8,2), want 0", s_draw);
    end
    en = 1'b1; spd = 2'd2;
    frame();
    spd = 2'd0;
    probe(4, 8);
    n_vec++;
    if (s_draw !== 1'b1) begin
      n_err++; $display("FAIL speed2_pos: got draw=%b at (4,8), want 1", s_draw);
    end
    probe(3, 8);
    n_vec++;
    if (s_draw !== 1'b0) begin
      n_err++; $display("FAIL speed2_x: got draw=%b at (3,8), want 0", s_draw);
    end
    probe(4, 7);
    n_vec++;
    if (s_draw !== 1'b0) begin
      n_err++; $display("FAIL speed2_y: got draw=%b at (4,7), want 0", s_draw);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cycles;
    apply_reset();
    busy_cycles = 0;
    fs = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 0) fs = 1'b0;
      if (c == 2) begin fs = 1'b1; en = 1'b0; spd = 2'd3; end
      if (c == 3) fs = 1'b0;
      if (d_busy === 1'b1) busy_cycles++;
    end
    en = 1'b1; spd = 2'd0;
    n_vec++;
    if (busy_cycles !== 8) begin
      n_err++; $display("FAIL sweep_len: got %0d busy cycles, want 8", busy_cycles);
    end
    probe(284, 169);
    n_vec++;
    if (d_draw !== 1'b1 || d_index !== 3'd7) begin
      n_err++; $display("FAIL ball7_step: got draw=%b idx=%0d, want 1/7", d_draw, d_index);
    end
    probe(283, 169);
    n_vec++;
    if (d_draw !== 1'b0) begin
      n_err++; $display("FAIL ball7_edge: got draw=%b at (283,169), want 0", d_draw);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hit_after_reset();
    test_overlap();
    test_single_frame();
    test_bounce();
    test_reset_mid_sweep();
    test_enable_speed();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
